// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 write-only sequencer: power-on wait, init commands, then 32-character refresh frames.
// Optional LCD_DIRTY_SKIP_EN: after a frame, wait in IDLE until content_changed requests another.
module lcd_refresh_ctrl #(
  parameter int T_POWERON = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_HOLD    = 2,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       content_changed,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       init_done,
  output logic       frame_done
);

  localparam int T_MAX_A = (T_POWERON > T_CLR) ? T_POWERON : T_CLR;
  localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_POWERON - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(T_CLR - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_L1_ADDR, S_L1_CHAR, S_L2_ADDR, S_L2_CHAR, S_FRAME_END, S_IDLE
  } main_t;

  typedef enum logic [2:0] {B_IDLE, B_SETUP, B_PULSE, B_HOLD, B_WAIT} bus_t;

  main_t            st, st_nxt;
  bus_t             ph, ph_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       idx, idx_nxt;
  logic             go;
  logic [7:0]       wr_byte;
  logic             wr_rs;
  logic             clr_q;
  logic [CNT_W-1:0] wait_last;
  logic             bdone;
  logic             addr_step;
`ifdef LCD_DIRTY_SKIP_EN
  logic             dirty;
`endif

  assign LCD_RW    = 1'b0;
  assign wait_last = clr_q ? CLR_LAST : CMD_LAST;
  assign bdone     = (ph == B_WAIT) && (cnt == wait_last);

  // Advance char_addr on entry to the last WAIT cycle so the source has a full cycle to settle.
  assign addr_step = ((st == S_L1_CHAR) || (st == S_L2_CHAR)) &&
                     (((ph == B_WAIT) && ((cnt + CNT_W'(1)) == wait_last)) ||
                      ((ph == B_HOLD) && (cnt == HOLD_LAST) && (wait_last == '0)));

  always_comb begin
    st_nxt  = st;
    idx_nxt = idx;
    go      = 1'b0;
    case (st)
      S_PWRUP:     if (cnt == PWR_LAST) begin
                     st_nxt  = S_INIT;
                     idx_nxt = '0;
                     go      = 1'b1;
                   end
      S_INIT:      if (bdone) begin
                     go = 1'b1;
                     if (idx == 5'd3) st_nxt = S_L1_ADDR;
                     else             idx_nxt = idx + 5'd1;
                   end
      S_L1_ADDR:   if (bdone) begin
                     go      = 1'b1;
                     st_nxt  = S_L1_CHAR;
                     idx_nxt = '0;
                   end
      S_L1_CHAR:   if (bdone) begin
                     go      = 1'b1;
                     idx_nxt = idx + 5'd1;
                     if (idx == 5'd15) st_nxt = S_L2_ADDR;
                   end
      S_L2_ADDR:   if (bdone) begin
                     go     = 1'b1;
                     st_nxt = S_L2_CHAR;
                   end
      S_L2_CHAR:   if (bdone) begin
                     if (idx == 5'd31) st_nxt = S_FRAME_END;
                     else begin
                       go      = 1'b1;
                       idx_nxt = idx + 5'd1;
                     end
                   end
`ifdef LCD_DIRTY_SKIP_EN
      S_FRAME_END: st_nxt = S_IDLE;
      S_IDLE:      if (dirty) begin
                     st_nxt = S_L1_ADDR;
                     go     = 1'b1;
                   end
`else
      S_FRAME_END: begin
                     st_nxt = S_L1_ADDR;
                     go     = 1'b1;
                   end
`endif
      default:     st_nxt = S_PWRUP;
    endcase

    // Byte for the write that starts on this edge, chosen from the state being entered.
    wr_byte = 8'h00;
    wr_rs   = 1'b0;
    case (st_nxt)
      S_INIT: begin
        case (idx_nxt[1:0])
          2'd0:    wr_byte = 8'h38;
          2'd1:    wr_byte = 8'h0C;
          2'd2:    wr_byte = 8'h01;
          default: wr_byte = 8'h06;
        endcase
      end
      S_L1_ADDR:            wr_byte = 8'h80;
      S_L2_ADDR:            wr_byte = 8'hC0;
      S_L1_CHAR, S_L2_CHAR: begin
        wr_byte = char_data;
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ph_nxt  = ph;
    cnt_nxt = cnt + CNT_W'(1);
    case (ph)
      B_IDLE:  if (st != S_PWRUP) cnt_nxt = '0;
      B_SETUP: if (cnt == SET_LAST)  begin ph_nxt = B_PULSE; cnt_nxt = '0; end
      B_PULSE: if (cnt == EN_LAST)   begin ph_nxt = B_HOLD;  cnt_nxt = '0; end
      B_HOLD:  if (cnt == HOLD_LAST) begin ph_nxt = B_WAIT;  cnt_nxt = '0; end
      B_WAIT:  if (bdone)            begin ph_nxt = B_IDLE;  cnt_nxt = '0; end
      default: begin ph_nxt = B_IDLE; cnt_nxt = '0; end
    endcase
    if (go) begin
      ph_nxt  = B_SETUP;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      st         <= S_PWRUP;
      ph         <= B_IDLE;
      cnt        <= '0;
      idx        <= '0;
      clr_q      <= 1'b0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_E      <= 1'b0;
      char_addr  <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st    <= st_nxt;
      ph    <= ph_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      LCD_E <= (ph_nxt == B_PULSE);
      if (go) begin
        LCD_DATA <= wr_byte;
        LCD_RS   <= wr_rs;
        clr_q    <= !wr_rs && (wr_byte == 8'h01);
      end
      if (addr_step) char_addr <= char_addr + 5'd1;
      if ((st == S_INIT) && (st_nxt == S_L1_ADDR)) init_done <= 1'b1;
      frame_done <= (st == S_FRAME_END);
    end
  end

`ifdef LCD_DIRTY_SKIP_EN
  // The init-completion request is consumed by the first frame, which starts on that same edge.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N)                                      dirty <= 1'b0;
    else if (content_changed)                         dirty <= 1'b1;
    else if ((st_nxt == S_L1_ADDR) && (st != S_L1_ADDR)) dirty <= 1'b0;
  end
`else
  logic unused_content_changed;
  assign unused_content_changed = content_changed;
`endif

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with short timing parameters (15-cycle writes, 35-cycle clear).
module tb_lcd_refresh_ctrl;

  localparam int T_EN = 3;

  logic       clk = 1'b0;
  logic       iRST_N = 1'b0;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       content_changed = 1'b0;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_E, init_done, frame_done;
  logic [7:0] src_off = 8'h41;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rises    = 0;
  int fd_cnt   = 0;
  int fd_last  = -1;
  logic prev_e = 1'b0;

  lcd_refresh_ctrl #(
    .T_POWERON(20), .T_SETUP(1), .T_EN(T_EN), .T_HOLD(1), .T_CMD(10), .T_CLR(30)
  ) dut (
    .iCLK_50MHZ(clk), .iRST_N(iRST_N), .char_addr(char_addr), .char_data(char_data),
    .content_changed(content_changed), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_E(LCD_E), .init_done(init_done), .frame_done(frame_done)
  );

  assign char_data = src_off + {3'b000, char_addr};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    n_checks++;
    assert (obsv === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obsv, expv, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (LCD_E === 1'b1 && prev_e === 1'b0) rises++;
    prev_e = LCD_E;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_last = cyc;
    end
  endtask

  task automatic pulse();
    content_changed = 1'b1;
    step();
    content_changed = 1'b0;
  endtask

  // Waits for the next E rise, then checks byte/RS in the setup cycle, at the rise,
  // the E width and the byte/RS in the hold cycle after E falls.
  task automatic chk_write(input logic [7:0] eb, input logic ers, input int ecyc, input string tag);
    int lim;
    int w;
    logic [7:0] pd;
    logic prs;
    lim = 0;
    pd  = LCD_DATA;
    prs = LCD_RS;
    while (LCD_E !== 1'b1 && lim < 200) begin
      pd  = LCD_DATA;
      prs = LCD_RS;
      step();
      lim++;
    end
    check({tag, " rise_timeout"}, 32'(lim < 200), 32'd1);
    if (ecyc >= 0) check({tag, " rise_cycle"}, cyc, ecyc);
    check({tag, " setup_data"}, {24'd0, pd}, {24'd0, eb});
    check({tag, " setup_rs"}, {31'd0, prs}, {31'd0, ers});
    check({tag, " rise_data"}, {24'd0, LCD_DATA}, {24'd0, eb});
    check({tag, " rise_rs"}, {31'd0, LCD_RS}, {31'd0, ers});
    w = 0;
    while (LCD_E === 1'b1 && w < 50) begin
      step();
      w++;
    end
    check({tag, " e_width"}, w, T_EN);
    check({tag, " hold_data"}, {24'd0, LCD_DATA}, {24'd0, eb});
    check({tag, " hold_rs"}, {31'd0, LCD_RS}, {31'd0, ers});
  endtask

  initial begin
    int lim;
    int r0;
    repeat (3) step();
    check("rst_e", {31'd0, LCD_E}, 0);
    check("rst_rs", {31'd0, LCD_RS}, 0);
    check("rst_rw", {31'd0, LCD_RW}, 0);
    check("rst_data", {24'd0, LCD_DATA}, 0);
    check("rst_addr", {27'd0, char_addr}, 0);
    check("rst_init_done", {31'd0, init_done}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);

    iRST_N = 1'b1;
    cyc = 0;
    chk_write(8'h38, 1'b0, 21, "init0");
    chk_write(8'h0C, 1'b0, 36, "init1");
    chk_write(8'h01, 1'b0, 51, "init2");
    chk_write(8'h06, 1'b0, 86, "init3");
    while (cyc < 99) step();
    check("init_done_c99", {31'd0, init_done}, 0);
    step();
    check("init_done_c100", {31'd0, init_done}, 1);
    check("rw_low", {31'd0, LCD_RW}, 0);

    chk_write(8'h80, 1'b0, 101, "l1_addr");
    check("addr_l1_start", {27'd0, char_addr}, 0);
    for (int n = 0; n < 16; n++) chk_write(8'(8'h41 + n), 1'b1, 101 + 15 * (n + 1), "l1_char");
    chk_write(8'hC0, 1'b0, 356, "l2_addr");
    check("addr_l2", {27'd0, char_addr}, 16);
    for (int n = 16; n < 32; n++) chk_write(8'(8'h41 + n), 1'b1, 101 + 15 * (n + 2), "l2_char");
    check("fd_none_yet", fd_cnt, 0);
    src_off = 8'h20;

`ifdef LCD_DIRTY_SKIP_EN
    while (cyc < 612) step();
    check("fd_count1", fd_cnt, 1);
    check("fd_cycle", fd_last, 611);
    r0 = rises;
    repeat (2000) step();
    check("idle_no_rise", rises - r0, 0);
    check("idle_e_low", {31'd0, LCD_E}, 0);
    pulse();
    chk_write(8'h80, 1'b0, -1, "dirty_l1_addr");
    chk_write(8'h20, 1'b1, -1, "dirty_char0");
    r0 = rises;
    repeat (1500) step();
    check("dirty_one_frame", rises - r0, 32);
    check("dirty_fd2", fd_cnt, 2);
    r0 = rises;
    pulse();
    repeat (100) step();
    pulse();
    repeat (100) step();
    pulse();
    repeat (2000) step();
    check("dirty_two_frames", rises - r0, 68);
    check("dirty_fd4", fd_cnt, 4);
    pulse();
`else
    chk_write(8'h80, 1'b0, 612, "f2_l1_addr");
    check("fd_count1", fd_cnt, 1);
    check("fd_cycle", fd_last, 611);
    chk_write(8'h20, 1'b1, 627, "f2_char0");
    chk_write(8'h21, 1'b1, 642, "f2_char1");
`endif

    lim = 0;
    while (LCD_E !== 1'b1 && lim < 100) begin
      step();
      lim++;
    end
    check("rst_wait_e", 32'(lim < 100), 1);
    #1 iRST_N = 1'b0;
    #1;
    check("async_e", {31'd0, LCD_E}, 0);
    check("async_data", {24'd0, LCD_DATA}, 0);
    check("async_init_done", {31'd0, init_done}, 0);
    check("async_addr", {27'd0, char_addr}, 0);
    step();
    step();
    iRST_N = 1'b1;
    cyc = 0;
    chk_write(8'h38, 1'b0, 21, "re_init0");
    check("re_init_done_low", {31'd0, init_done}, 0);
    chk_write(8'h0C, 1'b0, 36, "re_init1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
# lcd_refresh_ctrl

Write-only sequencer for the HD44780-compatible 16x2 character LCD on the 50 MHz board clock. After reset it runs the power-on wait and the controller init sequence. It then repeatedly streams 32 characters from a character source, the score/status formatter, into display RAM. It generates RS/E/DATA timing directly, so the score formatter only supplies character codes by address.

## Interface
Parameters (all in clock cycles):
- T_POWERON, 750000: wait after reset before first command (15 ms)
- T_SETUP, 2: RS/DATA valid before E rises
- T_EN, 12: E high width
- T_HOLD, 2: RS/DATA held after E falls
- T_CMD, 2000: post-write delay for normal commands and characters (40 us)
- T_CLR, 82000: post-write delay after clear-display 0x01 (1.64 ms)

Ports:
- iCLK_50MHZ  in  1  system clock
- iRST_N  in  1  asynchronous, active-low reset
- char_addr  out  5  character index, 0-15 = line 1, 16-31 = line 2
- char_data  in  8  ASCII code for char_addr, from the combinational lookup
- content_changed  in  1  one-cycle pulse when display content changes
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_E  out  1  LCD enable strobe
- init_done  out  1  high from completion of the init sequence until reset
- frame_done  out  1  one-cycle pulse after the 32nd character's post-write delay

## Operation
- Main FSM states: PWRUP, INIT(k = 0..3), L1_ADDR, L1_CHAR(n = 0..15), L2_ADDR, L2_CHAR(n = 16..31), FRAME_END.
- INIT sequence, commands in order: 0x38, 0x0C, 0x01, 0x06. init_done rises in the cycle the main FSM enters L1_ADDR.
- L1_ADDR writes command 0x80. L2_ADDR writes command 0xC0. Character writes have RS = 1; all others have RS = 0.
- Every write is executed by a bus sub-FSM with four phases:
  - SETUP: T_SETUP cycles, E = 0.
  - PULSE: T_EN cycles, E = 1.
  - HOLD: T_HOLD cycles, E = 0.
  - WAIT: T_CLR cycles if the byte is command 0x01, otherwise T_CMD cycles.
- LCD_DATA and LCD_RS are loaded in the first SETUP cycle. They are stable until the next write's first SETUP cycle.
- char_addr is updated to the next index in the last WAIT cycle of the preceding write. char_data is sampled in the first SETUP cycle of the character write, which gives the source at least one full cycle.
  - char_addr = 0 before and during L1_ADDR.
  - char_addr = 16 during L2_ADDR.
- FRAME_END asserts frame_done for one cycle, then enters L1_ADDR.
- Delay counters are wide enough for the largest parameter. The main FSM never advances while the sub-FSM is busy.

## Timing
- Reset values: LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00, char_addr = 0, init_done = 0, frame_done = 0, FSMs in PWRUP.
- Asserting reset at any point clears all state asynchronously. E falls immediately, even mid-pulse. The full power-up wait and init sequence restart on release.
- First E rise: cycle T_POWERON + T_SETUP after reset release (the first cycle after release is counted as cycle 0).
- Write length: T_SETUP + T_EN + T_HOLD + delay cycles. Consecutive writes abut with no idle cycles.
- Frame length: 34 writes, plus 1 cycle for FRAME_END.
- content_changed is ignored unless LCD_DIRTY_SKIP_EN is defined.

## Configuration
- LCD_DIRTY_SKIP_EN undefined:
  - Frames run back-to-back forever.
  - content_changed is unused.
- LCD_DIRTY_SKIP_EN defined:
  - A sticky dirty flag is set by content_changed and by the completion of init.
  - FRAME_END goes to an IDLE state. IDLE waits for the flag, then enters L1_ADDR.
  - The flag clears on entry to L1_ADDR. A pulse during a frame sets it again, so exactly one additional frame follows.
  - If a pulse coincides with the L1_ADDR entry cycle, the set wins.

## Test plan
Parameters for all scenarios: T_POWERON = 20, T_SETUP = 1, T_EN = 3, T_HOLD = 1, T_CMD = 10, T_CLR = 30. This gives 15-cycle writes and a 35-cycle clear.
- Power-up: release reset at cycle 0 -> first E rise at cycle 21 with RS = 0, DATA = 0x38; E is high for exactly 3 cycles.
- Init order and delays: monitor E rises -> bytes 0x38, 0x0C, 0x01, 0x06, 0x80; the gap from the 0x01 rise to the 0x06 rise is 35 cycles, all other gaps 15 cycles; init_done rises at cycle 100.
- Frame content: source returns 0x41 + char_addr -> RS = 1 bytes 0x41..0x50, then command 0xC0, then 0x51..0x60; frame_done pulses once, 511 cycles after init_done rises.
- Async reset mid-pulse: assert iRST_N low while E = 1 -> E = 0 in the same cycle with no clock edge; after release, init_done = 0 and the sequence restarts from 0x38.
- LCD_DIRTY_SKIP_EN defined: no content_changed after the first frame -> bus idle with E = 0 for 2000 cycles; a pulse -> exactly one further frame; two pulses within one frame -> exactly one extra frame.
- Setup/hold: for every E rise and fall, LCD_DATA and LCD_RS are unchanged from at least 1 cycle before the rise until at least 1 cycle after the fall.
